// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - Sequencer status/state types and instruction-class helpers.
`ifndef SEQ_DEFINE_SV
`include "define.sv"
`endif

package seq_pkg;

    typedef enum logic [1:0] {
        AOK = 2'd0,
        HLT = 2'd1,
        ADR = 2'd2,
        INS = 2'd3
    } stat_t;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        EXECUTE = 4'd3,
        MEMORY  = 4'd4,
        WRBACK  = 4'd5,
        PCUPD   = 4'd6,
        HALT    = 4'd7,
        ERR     = 4'd8
    } seq_state_t;

    function automatic logic uses_mem(input logic [`NIBBLE_WIDTH-1:0] ic);
        case (ic)
            `IRMMOVQ, `IMRMOVQ, `ICALL, `IRET, `IPUSHQ, `IPOPQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Conditional moves always pass through WRBACK; the datapath squashes the write.
    function automatic logic uses_wb(input logic [`NIBBLE_WIDTH-1:0] ic);
        case (ic)
            `IRRMOVQ, `IIRMOVQ, `IMRMOVQ, `IOPQ,
            `ICALL, `IRET, `IPUSHQ, `IPOPQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// rtl/seq_ctrl_if.sv - Control, memory-handshake and strobe bundle between core wrapper and sequencer.
`ifndef SEQ_DEFINE_SV
`include "define.sv"
`endif

interface seq_ctrl_if #(
    parameter int RETIRE_W = 32
);
    import seq_pkg::*;

    logic                     start;
    logic                     stop_req;
    logic                     clear;
    logic [`NIBBLE_WIDTH-1:0] icode;
    logic                     instr_valid;
    logic                     imem_req;
    logic                     imem_ack;
    logic                     imem_err;
    logic                     dmem_req;
    logic                     dmem_ack;
    logic                     dmem_err;
    logic                     en_fetch;
    logic                     en_decode;
    logic                     en_execute;
    logic                     en_memory;
    logic                     en_wrback;
    logic                     en_pc;
    logic                     busy;
    stat_t                    stat;
    logic [RETIRE_W-1:0]      retired;

    modport master (
        output start, stop_req, clear, icode, instr_valid,
               imem_ack, imem_err, dmem_ack, dmem_err,
        input  imem_req, dmem_req, en_fetch, en_decode, en_execute,
               en_memory, en_wrback, en_pc, busy, stat, retired
    );

    modport slave (
        input  start, stop_req, clear, icode, instr_valid,
               imem_ack, imem_err, dmem_ack, dmem_err,
        output imem_req, dmem_req, en_fetch, en_decode, en_execute,
               en_memory, en_wrback, en_pc, busy, stat, retired
    );

endinterface

// File: rtl/define.sv
// rtl/define.sv - Y86-64 instruction codes and field widths shared by the stage2 core.
`ifndef SEQ_DEFINE_SV
`define SEQ_DEFINE_SV

`define NIBBLE_WIDTH 4

`define IHALT   4'h0
`define INOP    4'h1
`define IRRMOVQ 4'h2
`define IIRMOVQ 4'h3
`define IRMMOVQ 4'h4
`define IMRMOVQ 4'h5
`define IOPQ    4'h6
`define IJXX    4'h7
`define ICALL   4'h8
`define IRET    4'h9
`define IPUSHQ  4'hA
`define IPOPQ   4'hB

`endif

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - Watchdog for one outstanding memory request; shared by fetch and data waits.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clear_i,
    input  logic waiting_i,
    input  logic ack_i,
    output logic timeout_o
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge sys_clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (waiting_i && !ack_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // An ack arriving in the final allowed cycle beats the timeout.
    assign timeout_o = waiting_i && !ack_i && (cnt_q == LAST);

endmodule

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - Multi-cycle Y86-64 sequencer: walks one instruction through the six stages and strobes the datapath.
`ifndef SEQ_DEFINE_SV
`include "define.sv"
`endif

module seq_ctrl
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic       sys_clk,
    input  logic       rst,
    seq_ctrl_if.slave  bus
);

    seq_state_t               state_q;
    stat_t                    stat_q;
    logic [RETIRE_W-1:0]      retired_q;
    logic [`NIBBLE_WIDTH-1:0] icode_q;

    logic waiting;
    logic mem_ack;
    logic wait_clear;
    logic timeout;

    assign waiting    = (state_q == FETCH) || (state_q == MEMORY);
    assign mem_ack    = (state_q == FETCH) ? bus.imem_ack : bus.dmem_ack;
    // Restart the watchdog on every transition into a wait state.
    assign wait_clear = ((state_q == IDLE) && bus.start)
                     || ((state_q == PCUPD) && !bus.stop_req)
                     || ((state_q == EXECUTE) && uses_mem(icode_q));

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .clear_i   (wait_clear),
        .waiting_i (waiting),
        .ack_i     (mem_ack),
        .timeout_o (timeout)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            stat_q    <= AOK;
            retired_q <= '0;
            icode_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) state_q <= FETCH;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        icode_q <= bus.icode;
                        if (bus.imem_err) begin
                            state_q <= ERR;
                            stat_q  <= ADR;
                        end else if (!bus.instr_valid) begin
                            state_q <= ERR;
                            stat_q  <= INS;
                        end else if (bus.icode == `IHALT) begin
                            state_q   <= HALT;
                            stat_q    <= HLT;
                            retired_q <= retired_q + 1'b1;
                        end else begin
                            state_q <= DECODE;
                        end
                    end else if (timeout) begin
                        state_q <= ERR;
                        stat_q  <= ADR;
                    end
                end
                DECODE: state_q <= EXECUTE;
                EXECUTE: begin
                    if (uses_mem(icode_q))     state_q <= MEMORY;
                    else if (uses_wb(icode_q)) state_q <= WRBACK;
                    else                       state_q <= PCUPD;
                end
                MEMORY: begin
                    if (bus.dmem_ack) begin
                        if (bus.dmem_err) begin
                            state_q <= ERR;
                            stat_q  <= ADR;
                        end else if (uses_wb(icode_q)) begin
                            state_q <= WRBACK;
                        end else begin
                            state_q <= PCUPD;
                        end
                    end else if (timeout) begin
                        state_q <= ERR;
                        stat_q  <= ADR;
                    end
                end
                WRBACK: state_q <= PCUPD;
                PCUPD: begin
                    retired_q <= retired_q + 1'b1;
                    state_q   <= bus.stop_req ? IDLE : FETCH;
                end
                HALT, ERR: begin
                    if (bus.clear) begin
                        state_q <= IDLE;
                        stat_q  <= AOK;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are suppressed in a reset cycle so an aborted instruction never commits.
    always_comb begin
        bus.en_fetch   = 1'b0;
        bus.en_decode  = 1'b0;
        bus.en_execute = 1'b0;
        bus.en_memory  = 1'b0;
        bus.en_wrback  = 1'b0;
        bus.en_pc      = 1'b0;
        if (!rst) begin
            bus.en_fetch   = (state_q == FETCH) && bus.imem_ack;
            bus.en_decode  = (state_q == DECODE);
            bus.en_execute = (state_q == EXECUTE);
            bus.en_memory  = (state_q == MEMORY) && bus.dmem_ack;
            bus.en_wrback  = (state_q == WRBACK);
            bus.en_pc      = (state_q == PCUPD);
        end
    end

    assign bus.imem_req = (state_q == FETCH);
    assign bus.dmem_req = (state_q == MEMORY);
    assign bus.busy     = (state_q != IDLE) && (state_q != HALT) && (state_q != ERR);
    assign bus.stat     = stat_q;
    assign bus.retired  = retired_q;

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
Multi-cycle sequencer for the stage2 Y86-64 core.
- Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY, WRBACK and PCUPD.
- Emits one-cycle enable strobes to each datapath stage. en_pc drives the PC-select stage's valid input.
- Handles instruction/data memory handshakes, halt, error status and a memory-wait watchdog. Sits above the datapath, below the top-level core wrapper.

Parameters:
MEM_TIMEOUT, 16, max cycles spent waiting for imem_ack/dmem_ack before ADR error (>=1)
RETIRE_W, 32, width of retired-instruction counter

Ports:
sys_clk  in  1  core clock
rst  in  1  synchronous, active-high reset
start  in  1  IDLE->FETCH request
stop_req  in  1  return to IDLE after current instruction retires
clear  in  1  leave HALT/ERR, return to IDLE
icode  in  `NIBBLE_WIDTH  instruction code from fetch, valid with imem_ack
instr_valid  in  1  fetch decoder says icode/ifun legal, valid with imem_ack
imem_req  out  1  instruction memory request, held until ack
imem_ack  in  1  instruction memory done
imem_err  in  1  instruction address error, valid with imem_ack
dmem_req  out  1  data memory request, held until ack
dmem_ack  in  1  data memory done
dmem_err  in  1  data address error, valid with dmem_ack
en_fetch, en_decode, en_execute, en_memory, en_wrback, en_pc  out  1 each  stage strobes
busy  out  1  high in every state except IDLE, HALT, ERR
stat  out  2  AOK=0, HLT=1, ADR=2, INS=3
retired  out  RETIRE_W  retired-instruction count, wraps

Behaviour:
Reset values:
- rst sampled high: state=IDLE; all outputs 0; stat=AOK; retired=0; icode_q=0; wait_cnt=0.
- rst mid-operation aborts the instruction and drops imem_req/dmem_req at that edge. No strobe is issued.

Strobes: combinational from state and acks. All high for at most one cycle per instruction.

IDLE:
- start=1 -> FETCH. Otherwise stay.
- start while busy is ignored.

FETCH:
- imem_req=1. An ack is allowed in the first FETCH cycle.
- On imem_ack: en_fetch=1; icode_q<=icode. Then:
  - imem_err -> ERR, stat=ADR
  - else !instr_valid -> ERR, stat=INS
  - else icode==`IHALT -> HALT, stat=HLT, retired++
  - else -> DECODE

DECODE: en_decode=1 for one cycle -> EXECUTE.

EXECUTE: en_execute=1 for one cycle. Next state:
- icode_q in MEM set -> MEMORY
- else in WB set -> WRBACK
- else -> PCUPD

MEMORY:
- dmem_req=1.
- On dmem_ack: en_memory=1. Then:
  - dmem_err -> ERR, stat=ADR
  - else in WB set -> WRBACK
  - else -> PCUPD

WRBACK: en_wrback=1 for one cycle -> PCUPD.

PCUPD:
- en_pc=1; retired++ (wraps at 2^RETIRE_W).
- stop_req=1 -> IDLE. Otherwise -> FETCH.

HALT, ERR:
- Sticky. stat held; no strobes; no requests.
- clear=1 -> IDLE with stat=AOK. clear is ignored in other states.

Instruction sets:
- MEM set: `IRMMOVQ, `IMRMOVQ, `ICALL, `IRET, `IPUSHQ, `IPOPQ.
- WB set: `IRRMOVQ, `IIRMOVQ, `IMRMOVQ, `IOPQ, `ICALL, `IRET, `IPUSHQ, `IPOPQ.
- Not in WB set: `INOP, `IRMMOVQ, `IJXX. The cmov condition is resolved in the datapath, not here.

Watchdog:
- wait_cnt clears on entry to FETCH or MEMORY and increments each cycle without ack.
- No ack in the cycle where wait_cnt==MEM_TIMEOUT-1 -> ERR, stat=ADR, request dropped.
- An ack in that same cycle wins over timeout.

Zero-wait latency, first FETCH cycle to en_pc inclusive:
- NOP/JXX: 4 cycles
- OPQ/IRMOVQ: 5 cycles
- RMMOVQ: 5 cycles
- MRMOVQ/CALL/RET/PUSH/POP: 6 cycles

Decomposition:
- Shared define.sv: `IHALT=0, `INOP=1, `IRRMOVQ=2, `IIRMOVQ=3, `IRMMOVQ=4, `IMRMOVQ=5, `IOPQ=6, `IJXX=7, `ICALL=8, `IRET=9, `IPUSHQ=A, `IPOPQ=B; `NIBBLE_WIDTH.
- Shared package seq_pkg: stat_t enum (AOK/HLT/ADR/INS) and seq_state_t enum (IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRBACK, PCUPD, HALT, ERR).
- One sub-module: mem_wait_timer. Inputs: clear-on-entry, waiting, ack. Output: timeout. Parameterised by MEM_TIMEOUT. It is shared by the FETCH and MEMORY waits.

Test Plan:
- Reset then start, icode=`IOPQ, zero-wait ack, stop_req=1 -> en_fetch/decode/execute/wrback/pc on cycles 1..5, no en_memory, retired=1, back to IDLE.
- icode=`IMRMOVQ, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, en_memory in 4th, then en_wrback, en_pc; retired=1.
- icode=`IHALT -> HALT, stat=1, retired=1, busy=0, no further imem_req; clear -> IDLE, stat=0.
- MEM_TIMEOUT=4, imem_ack never arrives -> ERR after exactly 4 FETCH cycles, stat=2, imem_req low next cycle; ack on 4th cycle instead -> DECODE, no error.
- imem_ack with instr_valid=0 -> ERR, stat=3, en_fetch pulsed once; dmem_ack with dmem_err=1 on `IPUSHQ -> ERR, stat=2, no en_wrback/en_pc.
- rst asserted while in MEMORY with dmem_req high -> next cycle IDLE, dmem_req=0, retired=0; RETIRE_W=2 with 5 NOPs -> retired=1.
